// File: rtl/regfile_sync_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sync_sb_if
//   Bundle of the register-file access signals shared between the decode /
//   writeback stages (master) and the register file itself (slave).
//
//   Read side : rd_addr1, rd_addr2 -> rd_data1, rd_data2, rd_busy1, rd_busy2
//               (outputs registered, valid one cycle after the address)
//   Write side: wr_en, wr_addr, wr_data
//   Hazards   : pend_set, pend_addr (mark a register as awaiting a producer)
//   Status    : ready (clear sweep finished, writes and pend_set honoured)
//
//   Handshake semantics: there is no per-transfer valid/ready pairing.
//   wr_en and pend_set act as qualifying valids and are only honoured on an
//   edge where ready is 1. ready is a level status that never drops except
//   through reset, so a master simply holds off issuing until it sees ready.
// ---------------------------------------------------------------------------
interface regfile_sync_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [ADDR_WIDTH-1:0] rd_addr2;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;
  logic                  rd_busy1;
  logic                  rd_busy2;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  pend_set;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  ready;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, ready
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, ready
  );
endinterface

// File: rtl/regfile_sync_sb.sv
// ---------------------------------------------------------------------------
// regfile_sync_sb
//   DEPTH x DATA_WIDTH register file for pipelined datapaths.
//   - two registered read ports (latency 1) with optional write-to-read bypass
//   - one write port
//   - optional hardwired zero register (entry 0)
//   - clear sweep after reset: one entry zeroed per cycle, then ready rises
//   - per-register pending-write scoreboard for decode-stage hazard checks
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high; restarts the clear sweep
//   bus        regfile_sync_sb_if.slave (read/write/pending/ready signals)
//   dbg_state  current FSM state (0 = CLEAR, 1 = RUN)
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module regfile_sync_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_sync_sb_if.slave       bus,
  output logic [0:0]             dbg_state
);

  // Index width actually needed to address DEPTH entries.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  // -------------------------------------------------------------------------
  // Address qualification helpers
  // -------------------------------------------------------------------------
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {{(32-ADDR_WIDTH){1'b0}}, a} < $unsigned(DEPTH);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rd_data1_q;
  logic [DATA_WIDTH-1:0] rd_data2_q;
  logic                  rd_busy1_q;
  logic                  rd_busy2_q;
  logic [DEPTH-1:0]      pend_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Truncated indices; only used after the matching in_range() check.
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] pend_idx;
  logic [IDX_W-1:0] rd_idx1;
  logic [IDX_W-1:0] rd_idx2;
  logic [IDX_W-1:0] clr_sel;

  assign wr_idx   = bus.wr_addr[IDX_W-1:0];
  assign pend_idx = bus.pend_addr[IDX_W-1:0];
  assign rd_idx1  = bus.rd_addr1[IDX_W-1:0];
  assign rd_idx2  = bus.rd_addr2[IDX_W-1:0];
  assign clr_sel  = clr_idx[IDX_W-1:0];

  // -------------------------------------------------------------------------
  // Next-state logic for RUN
  // -------------------------------------------------------------------------
  logic                  run;
  logic                  wr_ok;
  logic                  pend_ok;
  logic [DEPTH-1:0]      pend_nxt;
  logic [DATA_WIDTH-1:0] rd_nxt1;
  logic [DATA_WIDTH-1:0] rd_nxt2;
  logic                  busy_nxt1;
  logic                  busy_nxt2;

  assign run = (state == ST_RUN);

  assign wr_ok   = run && bus.wr_en && in_range(bus.wr_addr)
                   && !is_zero_reg(bus.wr_addr);
  assign pend_ok = run && bus.pend_set && in_range(bus.pend_addr)
                   && !is_zero_reg(bus.pend_addr);

  // Clear first, then set: a new producer issuing in the same cycle as the
  // old one retiring leaves the register pending.
  always_comb begin
    pend_nxt = pend_q;
    if (wr_ok) begin
      pend_nxt[wr_idx] = 1'b0;
    end
    if (pend_ok) begin
      pend_nxt[pend_idx] = 1'b1;
    end
  end

  // Read port 1: invalid and zero-register addresses read 0 before bypass is
  // considered, so a write to an ignored address can never be forwarded.
  always_comb begin
    rd_nxt1   = '0;
    busy_nxt1 = 1'b0;
    if (in_range(bus.rd_addr1)) begin
      busy_nxt1 = pend_nxt[rd_idx1];
      if (!is_zero_reg(bus.rd_addr1)) begin
        if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr1)) begin
          rd_nxt1 = bus.wr_data;
        end else begin
          rd_nxt1 = mem[rd_idx1];
        end
      end
    end
  end

  // Read port 2: identical rules to port 1.
  always_comb begin
    rd_nxt2   = '0;
    busy_nxt2 = 1'b0;
    if (in_range(bus.rd_addr2)) begin
      busy_nxt2 = pend_nxt[rd_idx2];
      if (!is_zero_reg(bus.rd_addr2)) begin
        if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr2)) begin
          rd_nxt2 = bus.wr_data;
        end else begin
          rd_nxt2 = mem[rd_idx2];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      ready_q    <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Reads and pending flags stay quiet until every entry is zeroed.
          rd_data1_q <= '0;
          rd_data2_q <= '0;
          rd_busy1_q <= 1'b0;
          rd_busy2_q <= 1'b0;
          clr_idx    <= clr_idx + ADDR_WIDTH'(1);
          if (clr_idx == LAST_IDX) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          rd_data1_q <= rd_nxt1;
          rd_data2_q <= rd_nxt2;
          rd_busy1_q <= busy_nxt1;
          rd_busy2_q <= busy_nxt2;
          pend_q     <= pend_nxt;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage array: no reset; the sweep zeroes it one entry per cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_sel] <= '0;
      end else if (wr_ok) begin
        mem[wr_idx] <= bus.wr_data;
      end
    end
  end

  assign bus.rd_data1 = rd_data1_q;
  assign bus.rd_data2 = rd_data2_q;
  assign bus.rd_busy1 = rd_busy1_q;
  assign bus.rd_busy2 = rd_busy2_q;
  assign bus.ready    = ready_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_regfile_sync_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sync_sb
//   Two instances share one set of driven inputs:
//     dut 0: ZERO_REG=1, BYPASS=1
//     dut 1: ZERO_REG=0, BYPASS=0
//   ADDR_WIDTH=6 with DEPTH=32 so addresses 32..63 are out of range.
//   A behavioural model (plain arrays) predicts every output each edge.
// ---------------------------------------------------------------------------
module tb_regfile_sync_sb;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- driven inputs ----------------
  logic [AW-1:0] drv_ra1, drv_ra2, drv_wa, drv_pa;
  logic          drv_we, drv_ps;
  logic [DW-1:0] drv_wd;

  regfile_sync_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  regfile_sync_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.rd_addr1  = drv_ra1;
  assign bus_a.rd_addr2  = drv_ra2;
  assign bus_a.wr_en     = drv_we;
  assign bus_a.wr_addr   = drv_wa;
  assign bus_a.wr_data   = drv_wd;
  assign bus_a.pend_set  = drv_ps;
  assign bus_a.pend_addr = drv_pa;
  assign bus_b.rd_addr1  = drv_ra1;
  assign bus_b.rd_addr2  = drv_ra2;
  assign bus_b.wr_en     = drv_we;
  assign bus_b.wr_addr   = drv_wa;
  assign bus_b.wr_data   = drv_wd;
  assign bus_b.pend_set  = drv_ps;
  assign bus_b.pend_addr = drv_pa;

  logic [0:0] dbg_a, dbg_b;

  regfile_sync_sb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .dbg_state(dbg_a)
  );

  regfile_sync_sb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_state(dbg_b)
  );

  // Observed outputs gathered per instance index.
  logic [DW-1:0] act_d1 [2];
  logic [DW-1:0] act_d2 [2];
  logic          act_b1 [2];
  logic          act_b2 [2];
  logic          act_rdy[2];
  assign act_d1[0]  = bus_a.rd_data1;
  assign act_d2[0]  = bus_a.rd_data2;
  assign act_b1[0]  = bus_a.rd_busy1;
  assign act_b2[0]  = bus_a.rd_busy2;
  assign act_rdy[0] = bus_a.ready;
  assign act_d1[1]  = bus_b.rd_data1;
  assign act_d2[1]  = bus_b.rd_data2;
  assign act_b1[1]  = bus_b.rd_busy1;
  assign act_b2[1]  = bus_b.rd_busy2;
  assign act_rdy[1] = bus_b.ready;

  // ---------------- scoreboard / model ----------------
  int            checks;
  int            errors;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0]    m_mem [2][DEPTH];
  bit   [DEPTH-1:0] m_pend[2];
  int               edges_since_reset;
  logic [DW-1:0]    e_d1[2], e_d2[2];
  logic             e_b1[2], e_b2[2];
  logic             e_ready;

  function automatic bit has_zero_reg(input int p);
    return p == 0;
  endfunction

  function automatic bit has_bypass(input int p);
    return p == 0;
  endfunction

  // Register contents seen by a read: a value as architected by the rules,
  // independent of how the hardware orders its logic.
  function automatic logic [DW-1:0] model_read(input int p, input int ra,
                                               input bit wv, input int wa,
                                               input logic [DW-1:0] wd);
    if (ra >= DEPTH) return '0;
    if (has_zero_reg(p) && ra == 0) return '0;
    if (has_bypass(p) && wv && wa == ra) return wd;
    return m_mem[p][ra];
  endfunction

  // Predict the outputs that the coming edge produces and advance the model.
  task automatic model_edge();
    int ra1, ra2, wa, pa;
    bit wv, pv;
    bit [DEPTH-1:0] np;
    ra1 = int'(drv_ra1);
    ra2 = int'(drv_ra2);
    wa  = int'(drv_wa);
    pa  = int'(drv_pa);
    if (reset) begin
      edges_since_reset = 0;
      e_ready = 1'b0;
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < DEPTH; i++) m_mem[p][i] = '0;
        m_pend[p] = '0;
        e_d1[p] = '0; e_d2[p] = '0; e_b1[p] = 1'b0; e_b2[p] = 1'b0;
      end
    end else if (edges_since_reset < DEPTH) begin
      edges_since_reset++;
      e_ready = (edges_since_reset == DEPTH);
      for (int p = 0; p < 2; p++) begin
        e_d1[p] = '0; e_d2[p] = '0; e_b1[p] = 1'b0; e_b2[p] = 1'b0;
      end
    end else begin
      e_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
        wv = drv_we && wa < DEPTH && !(has_zero_reg(p) && wa == 0);
        pv = drv_ps && pa < DEPTH && !(has_zero_reg(p) && pa == 0);
        np = m_pend[p];
        if (wv) np[wa] = 1'b0;
        if (pv) np[pa] = 1'b1;
        e_d1[p] = model_read(p, ra1, wv, wa, drv_wd);
        e_d2[p] = model_read(p, ra2, wv, wa, drv_wd);
        e_b1[p] = (ra1 < DEPTH) ? np[ra1] : 1'b0;
        e_b2[p] = (ra2 < DEPTH) ? np[ra2] : 1'b0;
        if (wv) m_mem[p][wa] = drv_wd;
        m_pend[p] = np;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    drv_ra1 = '0; drv_ra2 = '0; drv_we = 1'b0; drv_wa = '0;
    drv_wd = '0; drv_ps = 1'b0; drv_pa = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (3) tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_rdy[p] !== 1'b0 || act_d1[p] !== '0 || act_b1[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold dut%0d ready=%0b d1=%h b1=%0b want 0/0/0",
                 p, act_rdy[p], act_d1[p], act_b1[p]);
      end
    end
    reset = 1'b0;
    drv_ra1 = 6'd5; drv_ra2 = 6'd17;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (act_rdy[p] !== (e == DEPTH)) begin
          errors++;
          $display("FAIL ready_rise dut%0d edge %0d got %0b want %0b",
                   p, e, act_rdy[p], (e == DEPTH));
        end
      end
    end
    for (int a = 0; a < DEPTH; a += 7) begin
      drv_ra1 = AW'(a); drv_ra2 = AW'(a + 3);
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (act_d1[p] !== 32'h0 || act_d2[p] !== 32'h0) begin
          errors++;
          $display("FAIL post_clear_read dut%0d addr %0d got %h/%h want 0",
                   p, a, act_d1[p], act_d2[p]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    set_idle();
    drv_we = 1'b1; drv_wa = 6'd5; drv_wd = 32'hDEADBEEF;
    tick();
    set_idle();
    drv_ra1 = 6'd5;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d1[p] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_read_r5 dut%0d got %h want deadbeef", p, act_d1[p]);
      end
    end
    set_idle();
    drv_we = 1'b1; drv_wa = 6'd0; drv_wd = 32'h12345678;
    tick();
    set_idle();
    drv_ra1 = 6'd0;
    tick();
    for (int p = 0; p < 2; p++) begin
      logic [DW-1:0] want;
      want = has_zero_reg(p) ? 32'h0 : 32'h12345678;
      checks++;
      if (act_d1[p] !== want) begin
        errors++;
        $display("FAIL write_r0 dut%0d got %h want %h", p, act_d1[p], want);
      end
    end
  endtask

  task automatic test_bypass();
    set_idle();
    drv_we = 1'b1; drv_wa = 6'd7; drv_wd = 32'h00000001;
    tick();
    set_idle();
    drv_we = 1'b1; drv_wa = 6'd7; drv_wd = 32'hA5A5A5A5; drv_ra2 = 6'd7;
    tick();
    for (int p = 0; p < 2; p++) begin
      logic [DW-1:0] want;
      want = has_bypass(p) ? 32'hA5A5A5A5 : 32'h00000001;
      checks++;
      if (act_d2[p] !== want) begin
        errors++;
        $display("FAIL bypass dut%0d got %h want %h", p, act_d2[p], want);
      end
    end
    set_idle();
    drv_ra2 = 6'd7;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d2[p] !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL after_bypass dut%0d got %h want a5a5a5a5", p, act_d2[p]);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_idle();
    drv_ps = 1'b1; drv_pa = 6'd9;
    tick();
    set_idle();
    drv_ra1 = 6'd9;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_b1[p] !== 1'b1) begin
        errors++;
        $display("FAIL pend_set dut%0d got %0b want 1", p, act_b1[p]);
      end
    end
    drv_we = 1'b1; drv_wa = 6'd9; drv_wd = 32'h99;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_b1[p] !== 1'b0) begin
        errors++;
        $display("FAIL pend_clear dut%0d got %0b want 0", p, act_b1[p]);
      end
    end
    drv_ps = 1'b1; drv_pa = 6'd9;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_b1[p] !== 1'b1) begin
        errors++;
        $display("FAIL set_wins dut%0d got %0b want 1", p, act_b1[p]);
      end
    end
    set_idle();
    drv_ps = 1'b1; drv_pa = 6'd0; drv_ra1 = 6'd0; drv_ra2 = 6'd9;
    tick();
    for (int p = 0; p < 2; p++) begin
      logic want;
      want = has_zero_reg(p) ? 1'b0 : 1'b1;
      checks++;
      if (act_b1[p] !== want || act_b2[p] !== 1'b1) begin
        errors++;
        $display("FAIL pend_r0 dut%0d got %0b/%0b want %0b/1",
                 p, act_b1[p], act_b2[p], want);
      end
    end
  endtask

  task automatic test_dual_read();
    set_idle();
    drv_ra1 = 6'd5; drv_ra2 = 6'd5;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d1[p] !== 32'hDEADBEEF || act_d2[p] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL dual_read dut%0d got %h/%h want deadbeef",
                 p, act_d1[p], act_d2[p]);
      end
    end
    drv_ra1 = 6'd40; drv_ra2 = 6'd40;
    drv_we = 1'b1; drv_wa = 6'd40; drv_wd = 32'hFFFF0000;
    drv_ps = 1'b1; drv_pa = 6'd40;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d1[p] !== 32'h0 || act_d2[p] !== 32'h0 ||
          act_b1[p] !== 1'b0 || act_b2[p] !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range dut%0d got %h/%h busy %0b/%0b want 0",
                 p, act_d1[p], act_d2[p], act_b1[p], act_b2[p]);
      end
    end
  endtask

  task automatic test_clear_midrun();
    set_idle();
    drv_we = 1'b1; drv_wa = 6'd3; drv_wd = 32'h55;
    tick();
    set_idle();
    drv_ra1 = 6'd3;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d1[p] !== 32'h55) begin
        errors++;
        $display("FAIL r3_before dut%0d got %h want 55", p, act_d1[p]);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv_we = 1'b1; drv_wa = 6'd3; drv_wd = 32'hFFFFFFFF;
    drv_ps = 1'b1; drv_pa = 6'd3; drv_ra1 = 6'd3; drv_ra2 = 6'd9;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (act_rdy[p] !== (e == DEPTH) || act_d1[p] !== '0 || act_b1[p] !== 1'b0) begin
          errors++;
          $display("FAIL clear_sweep dut%0d edge %0d ready=%0b d1=%h b1=%0b",
                   p, e, act_rdy[p], act_d1[p], act_b1[p]);
        end
      end
    end
    set_idle();
    drv_ra1 = 6'd3; drv_ra2 = 6'd9;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (act_d1[p] !== 32'h0 || act_b1[p] !== 1'b0 || act_b2[p] !== 1'b0 ||
          act_rdy[p] !== 1'b1) begin
        errors++;
        $display("FAIL after_clear dut%0d d1=%h busy %0b/%0b ready=%0b want 0/0/0/1",
                 p, act_d1[p], act_b1[p], act_b2[p], act_rdy[p]);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] want;
    for (int c = 0; c < 500; c++) begin
      reset   = ($urandom_range(0, 249) == 0);
      drv_ra1 = AW'($urandom_range(0, 39));
      drv_ra2 = ($urandom_range(0, 3) == 0) ? drv_ra1 : AW'($urandom_range(0, 39));
      drv_we  = 1'($urandom_range(0, 1));
      drv_wa  = ($urandom_range(0, 2) == 0) ? drv_ra1 : AW'($urandom_range(0, 39));
      drv_wd  = DW'($urandom());
      drv_ps  = ($urandom_range(0, 2) == 0);
      drv_pa  = ($urandom_range(0, 3) == 0) ? drv_wa : AW'($urandom_range(0, 39));
      model_edge();
      exp_q.push_back(e_d1[0]);
      exp_q.push_back(e_d1[1]);
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front();
        checks++;
        if (act_d1[p] !== want || act_d2[p] !== e_d2[p] || act_b1[p] !== e_b1[p] ||
            act_b2[p] !== e_b2[p] || act_rdy[p] !== e_ready) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got d=%h/%h b=%0b/%0b r=%0b want d=%h/%h b=%0b/%0b r=%0b",
                   p, c, act_d1[p], act_d2[p], act_b1[p], act_b2[p], act_rdy[p],
                   want, e_d2[p], e_b1[p], e_b2[p], e_ready);
        end
      end
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    edges_since_reset = 0;
    e_ready = 1'b0;
    reset = 1'b1;
    set_idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_dual_read();
    test_clear_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sync_sb.md
Name: regfile_sync_sb

Overview:
- Parametrised successor to the single-cycle register bank, for pipelined datapath variants.
- Provides a DEPTH x DATA_WIDTH register file with:
  - two registered read ports (latency 1) with write-to-read bypass;
  - one write port;
  - an optional hardwired zero register;
  - a post-reset clear sweep FSM;
  - a per-register pending-write scoreboard for hazard detection by the decode stage.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register address width
DEPTH, 32, number of registers (must be <= 2**ADDR_WIDTH)
ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, never becomes pending
BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read output

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr1  in  ADDR_WIDTH  read port 1 address ($rs)
rd_addr2  in  ADDR_WIDTH  read port 2 address ($rt)
rd_data1  out  DATA_WIDTH  registered read data, port 1
rd_data2  out  DATA_WIDTH  registered read data, port 2
rd_busy1  out  1  registered pending flag for rd_addr1
rd_busy2  out  1  registered pending flag for rd_addr2
wr_en  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
pend_set  in  1  mark pend_addr as having an in-flight producer
pend_addr  in  ADDR_WIDTH  register to mark pending
ready  out  1  high when the clear sweep is complete and the block accepts writes

Behaviour:
- Reset (reset=1 at the edge):
  - state<=CLEAR, clr_idx<=0, ready<=0;
  - rd_data1/2<=0, rd_busy1/2<=0, all pending bits<=0.
  - Holding reset for several cycles keeps clr_idx at 0.
- FSM states: CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry clr_idx and increments clr_idx.
  - After the edge that clears entry DEPTH-1: state<=RUN, ready<=1. ready therefore rises on the DEPTH-th edge after reset deasserts.
  - While in CLEAR: wr_en and pend_set are ignored; rd_data1/2 and rd_busy1/2 are registered as 0.
- RUN state: no return to CLEAR except via reset. Reset mid-RUN restarts the sweep.
- Write (RUN, wr_en=1):
  - mem[wr_addr]<=wr_data at the edge.
  - Ignored when ZERO_REG=1 and wr_addr=0.
  - Ignored when wr_addr>=DEPTH.
- Read (RUN):
  - rd_dataN<=mem[rd_addrN] at the edge, so data is valid one cycle after the address is presented.
  - rd_addrN>=DEPTH reads 0.
  - ZERO_REG=1 and rd_addrN=0 reads 0 regardless of bypass.
- Bypass: BYPASS=1, wr_en=1 and wr_addr==rd_addrN (valid, non-zero-reg) gives rd_dataN<=wr_data (write-first). BYPASS=0 gives the old contents.
- Both read ports may use the same address; both return identical data.
- Scoreboard (RUN):
  - A write with wr_en clears pend[wr_addr].
  - pend_set sets pend[pend_addr].
  - Set and clear on the same address in the same cycle: set wins (a new producer has issued).
  - pend_set to address 0 is ignored when ZERO_REG=1.
  - Out-of-range addresses are ignored.
- rd_busyN<=pending bit for rd_addrN after applying this cycle's set/clear. A write to an address with simultaneous read and no new set therefore gives rd_busyN=0.
- No combinational path from inputs to outputs.

Test Plan:
- DEPTH=32: pulse reset for 3 cycles -> ready=0 for exactly 32 edges after deassert, then 1; reading any address returns 0x00000000.
- RUN: write 0xDEADBEEF to r5; next cycle rd_addr1=5 -> rd_data1=0xDEADBEEF one cycle later; write 0x12345678 to r0 then read r0 -> 0.
- BYPASS=1: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr2=7 (r7 old 0x1) -> next cycle rd_data2=0xA5A5A5A5; with BYPASS=0 -> 0x00000001.
- Scoreboard:
  - pend_set r9, then rd_addr1=9 -> rd_busy1=1;
  - write r9 -> rd_busy1=0;
  - simultaneous pend_set r9 and write r9 -> rd_busy1 stays 1;
  - pend_set r0 -> rd_busy=0.
- Write r3=0x55, then wr_en during CLEAR (reset pulsed mid-RUN) -> write ignored, r3 reads 0 after ready, all busy flags 0.
- Dual read: rd_addr1=rd_addr2=5 -> both ports return identical data; rd_addr=40 (ADDR_WIDTH=6, DEPTH=32) -> 0 and busy 0.
